alu_cmd_sequencer: RTL and testbench

Upstream command stage for the team's 4-bit combinational ALU (a, b, 2-bit op → y). It buffers operand/opcode commands in a small FIFO and issues them one at a time to the ALU. It captures each ALU result into a registered output with a valid/ready handshake, and keeps an accumulator so a command can use the previous result as operand A. All arithmetic stays in the ALU; this block only queues, sequences and registers.

---
 rtl/alu_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a 4-bit combinational ALU: queues operand/opcode commands,
// issues them one at a time, registers each result behind a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    input  logic                     cmd_acc,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [1:0]               alu_op,
    input  logic [3:0]               alu_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_data,
    output logic                     res_zero,
    output logic [3:0]               acc,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       use_acc;
    } entry_t;

    state_t          state;
    state_t          next_state;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            capture;
    logic            release_res;

    assign cmd_ready = (fifo_count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    release_res = 1'b1;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Storage array is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_acc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // acc is read at the load edge, so a chained command sees the result captured before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            acc       <= '0;
        end else begin
            if (pop) begin
                alu_a  <= head.use_acc ? acc : head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_y;
                res_zero  <= (alu_y == 4'd0);
                acc       <= alu_y;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU on its issue port:
// a vector table for single commands plus hand-written backpressure and reset sequences.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic [3:0] acc;
    logic [2:0] fifo_count;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    logic [3:0] model_acc;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       use_acc;
        logic [3:0] y;
        logic       zero;
    } vec_t;

    vec_t vecs [8];

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_acc    (cmd_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .acc        (acc),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_y = 4'd0;
        case (alu_op)
            2'b00: alu_y = alu_a + alu_b;
            2'b01: alu_y = alu_a - alu_b;
            2'b10: alu_y = alu_a & alu_b;
            2'b11: alu_y = alu_a | alu_b;
            default: alu_y = 4'd0;
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_output({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check_output({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check_output({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check_output({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check_output({tag, "_res_data"}, 32'(res_data), 32'd0);
        check_output({tag, "_res_zero"}, 32'(res_zero), 32'd0);
        check_output({tag, "_acc"}, 32'(acc), 32'd0);
        check_output({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One command through an idle sequencer: accept, wait for result, check, hand it off.
    task automatic apply_stimulus(input vec_t v);
        int  n;
        bit  seen;
        check_output("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_acc   = v.use_acc;
        tick();
        cmd_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            tick();
            n++;
            if (n == 1) begin
                check_output("exec_alu_a", 32'(alu_a), 32'(v.use_acc ? model_acc : v.a));
                check_output("exec_alu_b", 32'(alu_b), 32'(v.b));
                check_output("exec_alu_op", 32'(alu_op), 32'(v.op));
            end
            if (res_valid) seen = 1'b1;
        end
        check_output("res_latency", 32'(n), 32'd2);
        check_output("res_data", 32'(res_data), 32'(v.y));
        check_output("res_zero", 32'(res_zero), 32'(v.zero));
        check_output("acc", 32'(acc), 32'(v.y));
        model_acc = v.y;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_output("post_hs_res_valid", 32'(res_valid), 32'd0);
        check_output("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  idx;
        int  last_cyc;
        bit  got6;
        bit  will_accept;

        vecs[0] = '{op: 2'b00, a: 4'h3, b: 4'h4, use_acc: 1'b0, y: 4'h7, zero: 1'b0};
        vecs[1] = '{op: 2'b01, a: 4'h2, b: 4'h5, use_acc: 1'b0, y: 4'hD, zero: 1'b0};
        vecs[2] = '{op: 2'b00, a: 4'h9, b: 4'h7, use_acc: 1'b0, y: 4'h0, zero: 1'b1};
        vecs[3] = '{op: 2'b10, a: 4'hC, b: 4'h3, use_acc: 1'b0, y: 4'h0, zero: 1'b1};
        vecs[4] = '{op: 2'b00, a: 4'h0, b: 4'h5, use_acc: 1'b0, y: 4'h5, zero: 1'b0};
        vecs[5] = '{op: 2'b00, a: 4'hF, b: 4'h6, use_acc: 1'b1, y: 4'hB, zero: 1'b0};
        vecs[6] = '{op: 2'b10, a: 4'hF, b: 4'h3, use_acc: 1'b1, y: 4'h3, zero: 1'b0};
        vecs[7] = '{op: 2'b11, a: 4'hF, b: 4'h8, use_acc: 1'b1, y: 4'hB, zero: 1'b0};

        // Reset held with random inputs toggling.
        rst_n     = 1'b0;
        model_acc = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_acc   = 1'($urandom);
            res_ready = 1'($urandom);
            tick();
        end
        check_reset_values("rst");
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        tick();
        check_output("rst_release_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Backpressure: five commands absorbed (one in HOLD, four queued), sixth waits.
        for (int i = 0; i < 5; i++) begin
            check_output("bp_cmd_ready", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 4'(i + 1);
            cmd_b     = 4'd1;
            cmd_acc   = 1'b0;
            tick();
        end
        cmd_a = 4'd6;
        check_output("bp_full_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("bp_full_count", 32'(fifo_count), 32'd4);
        check_output("bp_hold_valid", 32'(res_valid), 32'd1);
        check_output("bp_hold_data", 32'(res_data), 32'd2);
        tick();
        check_output("bp_still_full", 32'(fifo_count), 32'd4);
        check_output("bp_hold_stable", 32'(res_data), 32'd2);

        res_ready = 1'b1;
        idx       = 0;
        last_cyc  = 0;
        got6      = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            if (res_valid) begin
                check_output("bp_result", 32'(res_data), 32'(idx + 2));
                if (idx > 0) check_output("bp_spacing", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                idx++;
            end
            will_accept = cmd_valid && cmd_ready;
            tick();
            if (will_accept) begin
                cmd_valid = 1'b0;
                got6      = 1'b1;
            end
        end
        check_output("bp_result_count", 32'(idx), 32'd6);
        check_output("bp_sixth_accepted", 32'(got6), 32'd1);
        tick();
        tick();
        check_output("bp_no_extra", 32'(res_valid), 32'd0);
        check_output("bp_drain_count", 32'(fifo_count), 32'd0);
        check_output("bp_drain_busy", 32'(busy), 32'd0);
        res_ready = 1'b0;
        model_acc = 4'd7;

        // Reset asserted between edges while a result is held and three commands are queued.
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 4'(i + 8);
            cmd_b     = 4'd2;
            cmd_acc   = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        check_output("mid_hold_valid", 32'(res_valid), 32'd1);
        check_output("mid_hold_count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick();
        rst_n     = 1'b1;
        model_acc = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("post_rst_no_stale", 32'(res_valid), 32'd0);
        end
        apply_stimulus('{op: 2'b00, a: 4'h1, b: 4'h1, use_acc: 1'b0, y: 4'h2, zero: 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
